// File: rtl/ntt_pkg.sv
// Shared types and constants for the NTT stage sequencer.
// Optional cycle counter is enabled by defining NTT_CTRL_CYCLE_CNT_EN.
package ntt_pkg;

    localparam int N_COEF = 256;
    localparam int LOG_N  = $clog2(N_COEF);

    typedef logic [LOG_N-1:0] addr_t;
    typedef logic [LOG_N-1:0] tw_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } ctrl_state_e;

endpackage

// File: rtl/ntt_addr_gen.sv
// Butterfly address generator: maps (stage, butterfly index) to operand
// addresses and twiddle index for CT (IS_NTT=1) or GS (IS_NTT=0) order.
module ntt_addr_gen
    import ntt_pkg::*;
#(
    parameter bit IS_NTT = 1'b1,
    parameter int N      = 256,
    localparam int LW    = $clog2(N)
) (
    input  logic [LW-1:0] s,
    input  logic [LW-1:0] j,
    output logic [LW-1:0] rd_addr0,
    output logic [LW-1:0] rd_addr1,
    output logic [LW-1:0] tw_idx
);

    localparam logic [LW-1:0] ONE = LW'(1);
    localparam logic [LW-1:0] TOP = LW'(LW - 1);

    logic [LW-1:0] hs;
    logic [LW-1:0] half;
    logic [LW-1:0] grp;
    logic [LW-1:0] k;
    logic [LW-1:0] base;

    // hs = log2(half); groups = N/(2*half) = 1 << (LW-1-hs)
    always_comb begin
        hs       = IS_NTT ? (TOP - s) : s;
        half     = ONE << hs;
        grp      = j >> hs;
        k        = j & (half - ONE);
        base     = grp << (hs + ONE);
        rd_addr0 = base | k;
        rd_addr1 = rd_addr0 + half;
        tw_idx   = (ONE << (TOP - hs)) + grp;
    end

endmodule

// File: rtl/ntt_stage_ctrl.sv
// In-place NTT/INTT sequencer: issues one butterfly per cycle, drains
// between stages. Define NTT_CTRL_CYCLE_CNT_EN to add the cycle_cnt port.
module ntt_stage_ctrl
    import ntt_pkg::*;
#(
    parameter bit IS_NTT = 1'b1,
    parameter int N      = 256,
    parameter int RD_LAT = 1,
    parameter int BF_LAT = 3,
    localparam int LW    = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          stall,
    output logic          busy,
    output logic          done,
    output logic [LW-1:0] stage,
    output logic          rd_en,
    output logic [LW-1:0] rd_addr0,
    output logic [LW-1:0] rd_addr1,
    output logic [LW-1:0] tw_idx,
    output logic          wr_en,
    output logic [LW-1:0] wr_addr0,
    output logic [LW-1:0] wr_addr1
`ifdef NTT_CTRL_CYCLE_CNT_EN
    ,
    output logic [31:0]   cycle_cnt
`endif
);

    localparam int TOTAL_LAT = RD_LAT + BF_LAT;
    localparam int DW        = $clog2(TOTAL_LAT + 1);

    localparam logic [LW-1:0] J_LAST = LW'(N / 2 - 1);
    localparam logic [LW-1:0] S_LAST = LW'(LW - 1);
    localparam logic [DW-1:0] D_LAST = DW'(TOTAL_LAT - 1);

    typedef struct packed {
        logic          en;
        logic [LW-1:0] a0;
        logic [LW-1:0] a1;
    } wb_t;

    ctrl_state_e   state_q, state_d;
    logic [LW-1:0] s_q, s_d;
    logic [LW-1:0] j_q, j_d;
    logic [DW-1:0] drn_q, drn_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic [LW-1:0] ga0, ga1, gtw;
    wb_t           dl_q [TOTAL_LAT];
    wb_t           dl_d [TOTAL_LAT];

    ntt_addr_gen #(
        .IS_NTT (IS_NTT),
        .N      (N)
    ) u_addr_gen (
        .s        (s_q),
        .j        (j_q),
        .rd_addr0 (ga0),
        .rd_addr1 (ga1),
        .tw_idx   (gtw)
    );

    // Addresses are gated so every issue output reads zero when idle.
    assign rd_en    = (state_q == ISSUE) && !stall;
    assign rd_addr0 = rd_en ? ga0 : '0;
    assign rd_addr1 = rd_en ? ga1 : '0;
    assign tw_idx   = rd_en ? gtw : '0;

    assign busy  = busy_q;
    assign done  = done_q;
    assign stage = s_q;

    assign wr_en    = dl_q[TOTAL_LAT-1].en;
    assign wr_addr0 = dl_q[TOTAL_LAT-1].a0;
    assign wr_addr1 = dl_q[TOTAL_LAT-1].a1;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        j_d     = j_q;
        drn_d   = drn_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    s_d     = '0;
                    j_d     = '0;
                    busy_d  = 1'b1;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    j_d = j_q + LW'(1);
                    if (j_q == J_LAST) begin
                        state_d = DRAIN;
                        drn_d   = '0;
                    end
                end
            end
            DRAIN: begin
                if (drn_q == D_LAST) begin
                    drn_d = '0;
                    if (s_q == S_LAST) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ISSUE;
                        s_d     = s_q + LW'(1);
                        j_d     = '0;
                    end
                end else begin
                    drn_d = drn_q + DW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // The write-back delay line is free-running and ignores stall.
    always_comb begin
        dl_d[0] = '{en: rd_en, a0: rd_addr0, a1: rd_addr1};
        for (int i = 1; i < TOTAL_LAT; i++) begin
            dl_d[i] = dl_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            j_q     <= '0;
            drn_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < TOTAL_LAT; i++) begin
                dl_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            j_q     <= j_d;
            drn_q   <= drn_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            for (int i = 0; i < TOTAL_LAT; i++) begin
                dl_q[i] <= dl_d[i];
            end
        end
    end

`ifdef NTT_CTRL_CYCLE_CNT_EN
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == IDLE && start) begin
            cnt_d = '0;
        end else if (busy_q && cnt_q != '1) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cycle_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Directed bench for ntt_stage_ctrl (NTT, N=16, RD_LAT=1, BF_LAT=2) and
// the standalone address generator in both NTT and INTT orders.
module tb_ntt_stage_ctrl;

    localparam int NC  = 16;
    localparam int LOG = 4;
    localparam int TL  = 3;

    typedef struct packed {
        logic       en;
        logic [3:0] a0;
        logic [3:0] a1;
        logic [3:0] tw;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       stall;
    logic       busy, done, rd_en, wr_en;
    logic [3:0] stage, rd_addr0, rd_addr1, tw_idx, wr_addr0, wr_addr1;
`ifdef NTT_CTRL_CYCLE_CNT_EN
    logic [31:0] cycle_cnt;
`endif

    logic [3:0] ag_s, ag_j;
    logic [3:0] fa0, fa1, ftw, ia0, ia1, itw;

    int  checks = 0;
    int  errors = 0;
    int  cyc    = 0;
    ev_t sched[$];

    always #5 clk = ~clk;

    ntt_stage_ctrl #(
        .IS_NTT (1'b1),
        .N      (NC),
        .RD_LAT (1),
        .BF_LAT (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .stall    (stall),
        .busy     (busy),
        .done     (done),
        .stage    (stage),
        .rd_en    (rd_en),
        .rd_addr0 (rd_addr0),
        .rd_addr1 (rd_addr1),
        .tw_idx   (tw_idx),
        .wr_en    (wr_en),
        .wr_addr0 (wr_addr0),
        .wr_addr1 (wr_addr1)
`ifdef NTT_CTRL_CYCLE_CNT_EN
        ,
        .cycle_cnt (cycle_cnt)
`endif
    );

    ntt_addr_gen #(.IS_NTT(1'b1), .N(NC)) u_ag_ntt (
        .s(ag_s), .j(ag_j), .rd_addr0(fa0), .rd_addr1(fa1), .tw_idx(ftw)
    );

    ntt_addr_gen #(.IS_NTT(1'b0), .N(NC)) u_ag_intt (
        .s(ag_s), .j(ag_j), .rd_addr0(ia0), .rd_addr1(ia1), .tw_idx(itw)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Expected per-cycle issue stream of an unstalled run, plus an
    // optional bubble of gap_len cycles inserted at index gap_at.
    task automatic build(input int gap_at, input int gap_len);
        ev_t e;
        int  half, grp, a;
        sched.delete();
        for (int s = 0; s < LOG; s++) begin
            for (int j = 0; j < NC / 2; j++) begin
                half = NC >> (s + 1);
                grp  = j / half;
                a    = grp * 2 * half + j % half;
                e.en = 1'b1;
                e.a0 = 4'(a);
                e.a1 = 4'(a + half);
                e.tw = 4'((1 << s) + grp);
                sched.push_back(e);
            end
            for (int d = 0; d < TL; d++) sched.push_back(ev_t'(0));
        end
        for (int g = 0; g < gap_len; g++) sched.insert(gap_at, ev_t'(0));
    endtask

    task automatic run_sched(input int gap_at, input int gap_len,
                             input bit start_in_done, input int exp_done);
        ev_t e, w;
        int  n, dcyc;
        build(gap_at, gap_len);
        n     = sched.size();
        start = 1'b1;
        cyc   = 0;
        tick();
        for (int c = 1; c <= n; c++) begin
            start = (c == 20);
            stall = (c - 1 >= gap_at) && (c - 1 < gap_at + gap_len);
            #1;
            e = sched[c-1];
            w = (c > TL) ? sched[c-1-TL] : ev_t'(0);
            check($sformatf("rd@%0d", c),
                  32'({rd_en, rd_addr0, rd_addr1, tw_idx}), 32'(e));
            check($sformatf("wr@%0d", c),
                  32'({wr_en, wr_addr0, wr_addr1}), 32'({w.en, w.a0, w.a1}));
            check($sformatf("busy@%0d", c), 32'(busy), 32'd1);
            tick();
        end
        start = 1'b0;
        stall = 1'b0;
        dcyc  = -1;
        for (int k = 0; k < 20; k++) begin
            if (done) begin
                dcyc = cyc;
                break;
            end
            tick();
        end
        check("done_cycle", 32'(dcyc), 32'(exp_done));
        start = start_in_done;
        tick();
        start = 1'b0;
        check("post_busy", 32'(busy), 32'd0);
        check("post_done", 32'(done), 32'd0);
        check("post_rd_en", 32'(rd_en), 32'd0);
`ifdef NTT_CTRL_CYCLE_CNT_EN
        check("cycle_cnt", cycle_cnt, 32'(exp_done));
`endif
    endtask

    initial begin
        #300000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        stall = 1'b0;
        ag_s  = '0;
        ag_j  = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_busy_done", 32'({busy, done}), 32'd0);
        check("rst_stage", 32'(stage), 32'd0);
        check("rst_rd", 32'({rd_en, rd_addr0, rd_addr1, tw_idx}), 32'd0);
        check("rst_wr", 32'({wr_en, wr_addr0, wr_addr1}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        ag_s = 4'd3; ag_j = 4'd5; #1;
        check("ntt_s3j5", 32'({fa0, fa1, ftw}), 32'({4'd10, 4'd11, 4'd13}));
        ag_s = 4'd0; ag_j = 4'd7; #1;
        check("ntt_s0j7", 32'({fa0, fa1, ftw}), 32'({4'd7, 4'd15, 4'd1}));
        ag_s = 4'd0; ag_j = 4'd0; #1;
        check("intt_s0j0", 32'({ia0, ia1, itw}), 32'({4'd0, 4'd1, 4'd8}));
        ag_s = 4'd3; ag_j = 4'd0; #1;
        check("intt_s3j0", 32'({ia0, ia1, itw}), 32'({4'd0, 4'd8, 4'd1}));
        ag_s = 4'd1; ag_j = 4'd3; #1;
        check("intt_s1j3", 32'({ia0, ia1, itw}), 32'({4'd5, 4'd7, 4'd5}));
        tick();

        // Plain run with start pulses while busy and in the done cycle.
        run_sched(-1, 0, 1'b1, 45);
        // Started in the cycle after done; 3-cycle stall mid-stage 1.
        run_sched(14, 3, 1'b0, 48);

        // Reset during the stage-2 drain.
        start = 1'b1;
        cyc   = 0;
        tick();
        start = 1'b0;
        while (cyc < 32) tick();
        check("pre_rst_wr_en", 32'(wr_en), 32'd1);
        check("pre_rst_stage", 32'(stage), 32'd2);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_wr_en", 32'(wr_en), 32'd0);
        check("mid_rst_all",
              32'({busy, done, stage, rd_en, rd_addr0, rd_addr1, tw_idx,
                   wr_addr0, wr_addr1}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("after_rst_wr@%0d", i), 32'(wr_en), 32'd0);
            check($sformatf("after_rst_busy@%0d", i), 32'(busy), 32'd0);
        end

        run_sched(-1, 0, 1'b0, 45);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
